// File: rtl/pipe_pkg.sv
// Shared types and constants for the scrolling pipe field: game states,
// gap patterns and the LFSR that picks between them.
package pipe_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_t;

    // Each pattern leaves a two-row gap for the bird to fly through.
    localparam logic [7:0] PATTERN [0:3] = '{8'hE7, 8'hCF, 8'hF3, 8'h9F};

    localparam logic [3:0] LFSR_SEED = 4'b1001;

    function automatic logic [3:0] lfsr_step(input logic [3:0] value);
        return {value[2:0], value[3] ^ value[2]};
    endfunction

endpackage

// File: rtl/pipe_scheduler_tick_divider.sv
// Scroll-rate divider: pulses tick on the last count of every TICK_DIV-cycle
// period while enabled, and sits at zero whenever enable is low.
module tick_divider #(
    parameter int TICK_DIV = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            count_reg <= '0;
        end else if (count_reg == LAST) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CW'(1);
        end
    end

    assign tick = enable && (count_reg == LAST);

endmodule

// File: rtl/pipe_scheduler.sv
// Game controller for the pipe field: scrolls and spawns pipe columns,
// detects bird/pipe collisions and keeps a saturating score.
module pipe_scheduler
    import pipe_pkg::*;
#(
    parameter int COLS     = 16,
    parameter int TICK_DIV = 1024,
    parameter int SPACING  = 4,
    parameter int BIRD_COL = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        bird_row,
    output logic [COLS*8-1:0] frame,
    output logic [7:0]        score,
    output logic              running,
    output logic              game_over
);

    localparam int SP_W = (SPACING > 1) ? $clog2(SPACING) : 1;
    localparam logic [SP_W-1:0] SP_RELOAD = SP_W'(SPACING - 1);

    state_t            state_reg;
    state_t            state_next;
    logic [COLS*8-1:0] frame_reg;
    logic [COLS*8-1:0] frame_shifted;
    logic [7:0]        score_reg;
    logic [3:0]        lfsr_reg;
    logic [SP_W-1:0]   spacing_reg;
    logic              running_reg;
    logic              game_over_reg;

    logic              tick;
    logic              in_run;
    logic              overlap;
    logic              scroll;
    logic              start_game;
    logic              spawn;
    logic [7:0]        spawn_col;
    logic [7:0]        bird_col_mask;
    logic [7:0]        behind_col_mask;
    logic              cleared;

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .clk    (clk),
        .reset  (reset),
        .enable (in_run),
        .tick   (tick)
    );

    assign in_run          = (state_reg == RUN);
    assign bird_col_mask   = frame_reg[BIRD_COL*8 +: 8];
    assign behind_col_mask = frame_reg[(BIRD_COL-1)*8 +: 8];
    assign overlap         = in_run && (|(bird_col_mask & bird_row));
    // A collision freezes the field on the very cycle it is seen.
    assign scroll          = tick && in_run && !overlap;
    assign start_game      = start && !in_run;
    assign spawn           = (spacing_reg == '0);
    assign spawn_col       = spawn ? PATTERN[lfsr_reg[1:0]] : 8'h00;
    assign cleared         = (behind_col_mask != 8'h00) && (bird_col_mask == 8'h00);

    generate
        for (genvar gi = 0; gi < COLS; gi++) begin : g_shift
            if (gi == COLS - 1) begin : g_new
                assign frame_shifted[gi*8 +: 8] = spawn_col;
            end else begin : g_move
                assign frame_shifted[gi*8 +: 8] = frame_reg[(gi+1)*8 +: 8];
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start)   state_next = RUN;
            RUN:     if (overlap) state_next = OVER;
            OVER:    if (start)   state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            running_reg   <= 1'b0;
            game_over_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            running_reg   <= (state_next == RUN);
            game_over_reg <= (state_next == OVER);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || start_game) begin
            frame_reg   <= '0;
            score_reg   <= 8'h00;
            lfsr_reg    <= LFSR_SEED;
            spacing_reg <= '0;
        end else if (scroll) begin
            frame_reg   <= frame_shifted;
            lfsr_reg    <= lfsr_step(lfsr_reg);
            spacing_reg <= spawn ? SP_RELOAD : spacing_reg - SP_W'(1);
            if (cleared && (score_reg != 8'hFF)) begin
                score_reg <= score_reg + 8'd1;
            end
        end
    end

    assign frame     = frame_reg;
    assign score     = score_reg;
    assign running   = running_reg;
    assign game_over = game_over_reg;

endmodule

// File: tb/tb_pipe_scheduler.sv
// Directed bench for pipe_scheduler: a vector table for the opening of a game,
// then hand-written sequences for saturation, reset, collision and restart.
module tb_pipe_scheduler;

    localparam int COLS     = 8;
    localparam int TICK_DIV = 4;
    localparam int SPACING  = 3;
    localparam int BIRD_COL = 2;

    logic              clk;
    logic              reset;
    logic              start;
    logic [7:0]        bird_row;
    logic [COLS*8-1:0] frame;
    logic [7:0]        score;
    logic              running;
    logic              game_over;

    int total;
    int bad;

    typedef struct {
        logic        start;
        logic [7:0]  bird;
        int          cycles;
        logic [63:0] frame;
        logic [7:0]  score;
        logic        running;
        logic        over;
    } vec_t;

    vec_t vecs [9];

    pipe_scheduler #(
        .COLS     (COLS),
        .TICK_DIV (TICK_DIV),
        .SPACING  (SPACING),
        .BIRD_COL (BIRD_COL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bird_row  (bird_row),
        .frame     (frame),
        .score     (score),
        .running   (running),
        .game_over (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end else begin
            $display("ok   %s: %h", name, actual);
        end
    endtask

    task automatic check_all(input string name, input logic [63:0] f, input logic [7:0] s,
                             input logic r, input logic o);
        check({name, ".frame"}, frame, f);
        check({name, ".score"}, {56'd0, score}, {56'd0, s});
        check({name, ".running"}, {63'd0, running}, {63'd0, r});
        check({name, ".game_over"}, {63'd0, game_over}, {63'd0, o});
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // Edge E0 samples start; tick n lands on edge E(4n).
        vecs[0] = '{1'b1, 8'h10,  1, 64'h0000_0000_0000_0000, 8'd0, 1'b1, 1'b0}; // E0
        vecs[1] = '{1'b0, 8'h10,  3, 64'h0000_0000_0000_0000, 8'd0, 1'b1, 1'b0}; // E3
        vecs[2] = '{1'b0, 8'h10,  1, 64'hCF00_0000_0000_0000, 8'd0, 1'b1, 1'b0}; // tick1
        vecs[3] = '{1'b0, 8'h10,  8, 64'h0000_CF00_0000_0000, 8'd0, 1'b1, 1'b0}; // tick3
        vecs[4] = '{1'b0, 8'h10, 12, 64'h0000_CF00_00CF_0000, 8'd0, 1'b1, 1'b0}; // tick6
        vecs[5] = '{1'b0, 8'h10,  4, 64'h9F00_00CF_0000_CF00, 8'd0, 1'b1, 1'b0}; // tick7
        vecs[6] = '{1'b0, 8'h10,  4, 64'h009F_0000_CF00_00CF, 8'd1, 1'b1, 1'b0}; // tick8
        vecs[7] = '{1'b0, 8'h10, 12, 64'h00F3_0000_9F00_00CF, 8'd2, 1'b1, 1'b0}; // tick11
        vecs[8] = '{1'b0, 8'h00,  4, 64'h0000_F300_009F_0000, 8'd2, 1'b1, 1'b0}; // tick12

        reset    = 1'b1;
        start    = 1'b0;
        bird_row = 8'h00;
        step(2);
        reset = 1'b0;
        step(20);
        check_all("reset_idle", 64'd0, 8'd0, 1'b0, 1'b0);

        for (int i = 0; i < 9; i++) begin
            start    = vecs[i].start;
            bird_row = vecs[i].bird;
            step(1);
            start = 1'b0;
            step(vecs[i].cycles - 1);
            check_all($sformatf("vec%0d", i), vecs[i].frame, vecs[i].score,
                      vecs[i].running, vecs[i].over);
        end

        // bird_row = 0 never collides, so the game runs until score saturates.
        bird_row = 8'h00;
        for (int k = 0; k < 5000 && score !== 8'd255; k++) step(1);
        check("sat_reach", {56'd0, score}, 64'd255);
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("start_ignored.running", {63'd0, running}, 64'd1);
        check("start_ignored.score", {56'd0, score}, 64'd255);
        step(200);
        check("sat_hold.score", {56'd0, score}, 64'd255);
        check("sat_hold.running", {63'd0, running}, 64'd1);

        reset = 1'b1;
        start = 1'b1;
        step(1);
        reset = 1'b0;
        start = 1'b0;
        check_all("reset_midgame", 64'd0, 8'd0, 1'b0, 1'b0);
        step(10);
        check_all("reset_then_idle", 64'd0, 8'd0, 1'b0, 1'b0);

        // Fresh game; bird moves into the pipe's solid rows on the tick-7 cycle.
        bird_row = 8'h10;
        start    = 1'b1;
        step(1);
        start = 1'b0;
        step(24);
        check_all("coll_pre", 64'h0000_CF00_00CF_0000, 8'd0, 1'b1, 1'b0);
        step(3);
        bird_row = 8'h01;
        check_all("coll_e27", 64'h0000_CF00_00CF_0000, 8'd0, 1'b1, 1'b0);
        step(1);
        check_all("coll_hit", 64'h0000_CF00_00CF_0000, 8'd0, 1'b0, 1'b1);
        step(50);
        check_all("coll_frozen", 64'h0000_CF00_00CF_0000, 8'd0, 1'b0, 1'b1);

        bird_row = 8'h00;
        start    = 1'b1;
        step(1);
        start = 1'b0;
        check_all("restart", 64'd0, 8'd0, 1'b1, 1'b0);
        step(4);
        check_all("restart_spawn", 64'hCF00_0000_0000_0000, 8'd0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_scheduler.md
# pipe_scheduler

Game-level controller for the scrolling pipe field on the 8-row LED matrix. It owns a COLS-wide frame of 8-bit column masks and runs the idle/run/over game state machine. On each scroll tick it shifts the field one column left and spawns a new pipe column every SPACING ticks, choosing the gap pattern from an LFSR. It also checks collisions against the bird's row mask and keeps the score. It replaces free-running per-pipe pattern cyclers and sits between the bird logic and the display driver.

## Interface
- COLS, 16, number of display columns (≥ 4)
- TICK_DIV, 1024, clk cycles per scroll tick (≥ 2)
- SPACING, 4, ticks between spawned pipes (≥ 2)
- BIRD_COL, 3, column index occupied by the bird (1 ≤ BIRD_COL < COLS-1)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins a game from IDLE or OVER
- bird_row  in  8  one-hot row mask of bird (bit 0 = top row)
- frame  out  COLS*8  column masks; bits [8c+7:8c] = column c, 1 = pipe lit; column 0 leftmost
- score  out  8  pipes passed, saturating at 255
- running  out  1  high in RUN
- game_over  out  1  high in OVER

## Operation
- States: IDLE → RUN on start. RUN → OVER on collision. OVER → RUN on start. Any state → IDLE on reset.
- On start: frame = 0, score = 0, tick counter = 0, spacing counter = 0, LFSR = 4'b1001.
- Tick counter counts 0..TICK_DIV-1 in RUN only; it is held at 0 in IDLE/OVER. A scroll tick occurs when the count is TICK_DIV-1; the counter then wraps to 0.
- On a scroll tick:
  - Shift frame left: column c ← column c+1.
  - New column COLS-1 = PATTERN[lfsr[1:0]] if the spacing counter is 0, else 8'h00.
  - Spacing counter reloads to SPACING-1 on a spawn, else decrements.
  - LFSR advances every tick: {lfsr[2:0], lfsr[3]^lfsr[2]}.
- Patterns (gap of 2 rows): PATTERN0 = 8'hE7, PATTERN1 = 8'hCF, PATTERN2 = 8'hF3, PATTERN3 = 8'h9F.
- Score: on a scroll tick in which pre-shift column BIRD_COL-1 is nonzero, and pre-shift column BIRD_COL is 8'h00, the pipe has cleared the bird; score increments, saturating at 255.
- Collision: combinational overlap = |(frame column BIRD_COL & bird_row). In RUN, overlap forces next state OVER. Any scroll tick in the same cycle is suppressed: no shift, no score, no LFSR advance.
- OVER freezes frame and score until start or reset.
- start is ignored in RUN.
- bird_row = 0 never collides.

## Timing
- Reset values: frame = 0, score = 0, running = 0, game_over = 0, state IDLE, LFSR = 4'b1001, all counters 0.
- All outputs are registered.
- running goes high at the edge that samples start.
- The first scroll tick occurs TICK_DIV cycles after start is sampled. frame/score update at the edge ending the tick cycle.
- game_over goes high, and running low, at the edge following the first cycle in which overlap is seen in RUN: 1-cycle latency.
- Reset mid-game takes priority over start and collision at the same edge.

## Structure
- pipe_pkg:
  - state enum {IDLE, RUN, OVER}
  - PATTERN[0:3] constant array
  - LFSR_SEED = 4'b1001
- Sub-module tick_divider (parameter TICK_DIV; inputs clk, reset, enable; output tick pulse). It clears to 0 when enable is low.
- LFSR, spacing counter, shift register, score and FSM all live in pipe_scheduler.

## Test plan
Bench parameters: COLS = 8, TICK_DIV = 4, SPACING = 3, BIRD_COL = 2.

- **Reset:** reset 2 cycles, then idle for 20 cycles → frame = 0, score = 0, running = 0; no shifting occurs.
- **First spawn:** start pulse → running = 1 next edge; after 4 cycles column 7 = 8'hCF; after two more ticks column 7 = 8'h00 and column 5 = 8'hCF.
- **Scoring:** bird_row = 8'h10 (inside the 8'hCF gap) held → after the pipe passes column 2, score = 1; continue until score reaches 255, then further passes leave score = 255.
- **Collision:** bird_row = 8'h01 when a pipe reaches column 2 → game_over = 1 one cycle later. Frame and score stay frozen for 50 cycles; that same tick produces no score increment.
- **Restart:** start pulse while in OVER → frame = 0, score = 0, running = 1; the first spawned column is 8'hCF again (LFSR reseeded).
- **Reset mid-game:** reset asserted together with start during RUN → IDLE, all outputs 0 at the next edge.
